// File: rtl/top_datapath_pkg.sv
// Shared widths and depth constants for the top_datapath block.
// The register file, MAC and divider all size their state from these values.
package top_datapath_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int MUL_W  = 16;
  localparam int ACC_W  = 64;
  localparam int CNT_W  = 7;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PROD_W = DATA_W + MUL_W;

endpackage

// File: rtl/top_datapath_regfile.sv
// 64x32 register file: one write port, one registered write-first read port,
// reset clear of every word, and a registered read/write collision flag.
module top_regfile
  import top_datapath_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              collide_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              collide_q, collide_d;

  // A same-address write bypasses the array so the read sees the new word.
  always_comb begin
    collide_d = we_i && (waddr_i == raddr_i);
    rdata_d   = collide_d ? wdata_i : mem_q[raddr_i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q   <= '0;
      collide_q <= 1'b0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      rdata_q   <= rdata_d;
      collide_q <= collide_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign collide_o = collide_q;

endmodule

// File: rtl/top_datapath.sv
// Leaf datapath: register file, 64-bit multiply-accumulate with sticky
// overflow, and a programmable terminal-count divider. All outputs registered.
module top_datapath
  import top_datapath_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] in1,
  input  logic [ADDR_W-1:0] in2,
  input  logic              h2,
  input  logic              f9,
  input  logic              jk,
  input  logic              j99,
  input  logic [DATA_W-1:0] bus_A,
  input  logic [CNT_W-1:0]  clk_T,
  input  logic [MUL_W-1:0]  module_Bus_B,
  output logic              wrr_898,
  output logic              jjh,
  output logic [ACC_W-1:0]  d877,
  output logic [DATA_W-1:0] data_rd_T,
  output logic              f459_87_
);

  top_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_i      (h2),
    .waddr_i   (in1),
    .raddr_i   (in2),
    .wdata_i   (bus_A),
    .rdata_o   (data_rd_T),
    .collide_o (f459_87_)
  );

  logic [PROD_W-1:0] product;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;

  assign product = {{(PROD_W-DATA_W){1'b0}}, bus_A} * {{(PROD_W-MUL_W){1'b0}}, module_Bus_B};
  // One extra bit on the adder captures the carry out of bit 63.
  assign sum     = {1'b0, acc_q} + {{(ACC_W+1-PROD_W){1'b0}}, product};

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (jk) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (f9) begin
      acc_d = sum[ACC_W-1:0];
      ovf_d = ovf_q | sum[ACC_W];
    end
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Counter wraps naturally at 2**CNT_W, so lowering clk_T below the
  // current count costs a full wrap before the next terminal count.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (j99) begin
      if (cnt_q == clk_T) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign d877    = acc_q;
  assign jjh     = ovf_q;
  assign wrr_898 = tick_q;

endmodule

// File: tb/tb_top_datapath.sv
// Self-checking bench for top_datapath: table-driven register-file vectors with
// a read-data scoreboard, plus MAC, overflow, divider and mid-run reset sequences.
module tb_top_datapath;
  import top_datapath_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [ADDR_W-1:0] in1, in2;
  logic              h2, f9, jk, j99;
  logic [DATA_W-1:0] bus_A;
  logic [CNT_W-1:0]  clk_T;
  logic [MUL_W-1:0]  module_Bus_B;
  logic              wrr_898, jjh, f459_87_;
  logic [ACC_W-1:0]  d877;
  logic [DATA_W-1:0] data_rd_T;

  top_datapath dut (
    .clk          (clk),
    .reset        (reset),
    .in1          (in1),
    .in2          (in2),
    .h2           (h2),
    .f9           (f9),
    .jk           (jk),
    .j99          (j99),
    .bus_A        (bus_A),
    .clk_T        (clk_T),
    .module_Bus_B (module_Bus_B),
    .wrr_898      (wrr_898),
    .jjh          (jjh),
    .d877         (d877),
    .data_rd_T    (data_rd_T),
    .f459_87_     (f459_87_)
  );

  // ---------------- scoreboard / models ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [ACC_W-1:0]  acc_m;
  logic              ovf_m;
  logic [CNT_W-1:0]  cnt_m;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] exp_rd;
    logic              exp_col;
  } rf_vec_t;
  rf_vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic models_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    acc_m = '0;
    ovf_m = 1'b0;
    cnt_m = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic rf_drive(input logic we, input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] ra,
                          input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_rd,
                          input logic exp_col);
    logic [DATA_W:0] e;
    h2 = we; in1 = wa; in2 = ra; bus_A = wd;
    exp_q.push_back({exp_col, exp_rd});
    if (we) mem_m[wa] = wd;
    step();
    if (exp_q.size() == 0) begin
      check("rf_queue_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("rf_rd_data", 64'(data_rd_T), 64'(e[DATA_W-1:0]));
      check("rf_collide", 64'(f459_87_), 64'(e[DATA_W]));
    end
    h2 = 1'b0;
  endtask

  task automatic rf_model_drive(input logic we, input logic [ADDR_W-1:0] wa,
                                input logic [ADDR_W-1:0] ra, input logic [DATA_W-1:0] wd);
    logic col;
    col = we && (wa == ra);
    rf_drive(we, wa, ra, wd, col ? wd : mem_m[ra], col);
  endtask

  task automatic mac_step(input logic f, input logic c, input logic [DATA_W-1:0] a,
                          input logic [MUL_W-1:0] b, input bit do_check);
    logic [ACC_W:0] s;
    f9 = f; jk = c; bus_A = a; module_Bus_B = b;
    if (c) begin
      acc_m = '0;
      ovf_m = 1'b0;
    end else if (f) begin
      s = {1'b0, acc_m} + ({33'b0, a} * {49'b0, b});
      acc_m = s[ACC_W-1:0];
      if (s[ACC_W]) ovf_m = 1'b1;
    end
    step();
    if (do_check) begin
      check("mac_acc", d877, acc_m);
      check("mac_ovf", 64'(jjh), 64'(ovf_m));
    end
    f9 = 1'b0; jk = 1'b0;
  endtask

  task automatic div_step(input logic j, input logic [CNT_W-1:0] t);
    logic exp_tick;
    j99 = j; clk_T = t;
    exp_tick = 1'b0;
    if (j) begin
      if (cnt_m == t) begin
        cnt_m = '0;
        exp_tick = 1'b1;
      end else begin
        cnt_m = cnt_m + 7'd1;
      end
    end
    step();
    check("div_tick", 64'(wrr_898), 64'(exp_tick));
  endtask

  task automatic div_until_pulse(input logic [CNT_W-1:0] t, input int bound, output int n);
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      div_step(1'b1, t);
      if (wrr_898 === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wrr_898"}, 64'(wrr_898), 64'd0);
    check({tag, "_jjh"}, 64'(jjh), 64'd0);
    check({tag, "_d877"}, d877, 64'd0);
    check({tag, "_data_rd_T"}, 64'(data_rd_T), 64'd0);
    check({tag, "_f459_87_"}, 64'(f459_87_), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int a;
    bit found;
    bit early;

    reset = 1'b1; in1 = '0; in2 = '0; h2 = 1'b0; f9 = 1'b0; jk = 1'b0; j99 = 1'b0;
    bus_A = '0; clk_T = '0; module_Bus_B = '0;
    models_clear();
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;

    // register file: {we, wa, ra, wd, expected read, expected collision}
    vecs[0] = '{1'b0, 6'd0,  6'd41, 32'd0,          32'd0,          1'b0};
    vecs[1] = '{1'b1, 6'd1,  6'd0,  32'd363495322,  32'd0,          1'b0};
    vecs[2] = '{1'b0, 6'd0,  6'd1,  32'd0,          32'd363495322,  1'b0};
    vecs[3] = '{1'b1, 6'd41, 6'd41, 32'd7,          32'd7,          1'b1};
    vecs[4] = '{1'b0, 6'd0,  6'd41, 32'd0,          32'd7,          1'b0};
    vecs[5] = '{1'b1, 6'd63, 6'd1,  32'hDEADBEEF,   32'd363495322,  1'b0};
    vecs[6] = '{1'b0, 6'd0,  6'd63, 32'd0,          32'hDEADBEEF,   1'b0};
    vecs[7] = '{1'b1, 6'd63, 6'd63, 32'h12345678,   32'h12345678,   1'b1};
    vecs[8] = '{1'b0, 6'd5,  6'd63, 32'hFFFFFFFF,   32'h12345678,   1'b0};
    for (int i = 0; i < 9; i++) begin
      rf_drive(vecs[i].we, vecs[i].wa, vecs[i].ra, vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_col);
    end

    // random traffic over a narrow address range to provoke collisions
    for (int i = 0; i < 40; i++) begin
      rf_model_drive(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                     6'($urandom_range(0, 7)), $urandom);
    end

    // multiply-accumulate
    mac_step(1'b1, 1'b0, 32'd363495322, 16'd53392, 1'b1);
    check("mac_first", d877, 64'd19407742232224);
    mac_step(1'b1, 1'b0, 32'd363495322, 16'd53392, 1'b1);
    check("mac_second", d877, 64'd38815484464448);
    check("mac_second_ovf", 64'(jjh), 64'd0);
    mac_step(1'b0, 1'b0, 32'd99, 16'd99, 1'b1);
    mac_step(1'b1, 1'b1, 32'd363495322, 16'd53392, 1'b1);
    check("mac_jk_priority", d877, 64'd0);
    mac_step(1'b1, 1'b0, 32'hFFFFFFFF, 16'hFFFF, 1'b1);

    // overflow: accumulate the largest product until the 64-bit sum carries
    found = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      mac_step(1'b1, 1'b0, 32'hFFFFFFFF, 16'hFFFF, 1'b0);
      if (ovf_m) begin
        found = 1'b1;
        break;
      end
      if (jjh !== 1'b0) early = 1'b1;
    end
    check("ovf_reached", 64'(found), 64'd1);
    check("ovf_not_early", 64'(early), 64'd0);
    check("ovf_wrapped_acc", d877, acc_m);
    check("ovf_flag", 64'(jjh), 64'd1);
    for (int i = 0; i < 3; i++) mac_step(1'b0, 1'b0, 32'd0, 16'd0, 1'b1);
    mac_step(1'b1, 1'b0, 32'd1, 16'd1, 1'b1);
    check("ovf_sticky", 64'(jjh), 64'd1);
    mac_step(1'b0, 1'b1, 32'd0, 16'd0, 1'b1);
    check("ovf_jk_clear_flag", 64'(jjh), 64'd0);
    check("ovf_jk_clear_acc", d877, 64'd0);
    mac_step(1'b1, 1'b0, 32'd5, 16'd3, 1'b1);
    check("mac_small", d877, 64'd15);

    // divider
    div_until_pulse(7'd71, 200, n);
    check("div_first_period", 64'(n), 64'd72);
    div_until_pulse(7'd71, 200, n);
    check("div_period", 64'(n), 64'd72);
    for (int i = 0; i < 30; i++) div_step(1'b1, 7'd71);
    for (int i = 0; i < 10; i++) div_step(1'b0, 7'd71);
    div_until_pulse(7'd71, 200, n);
    check("div_paused_period", 64'(30 + 10 + n), 64'd82);
    for (int i = 0; i < 5; i++) begin
      div_step(1'b1, 7'd0);
      check("div_every_cycle", 64'(wrr_898), 64'd1);
    end
    for (int i = 0; i < 30; i++) div_step(1'b1, 7'd100);
    div_until_pulse(7'd20, 300, n);
    check("div_wrap_latency", 64'(n), 64'd119);

    // reset mid-operation: accumulator nonzero, divider at 50, memory populated
    for (int i = 0; i < 50; i++) div_step(1'b1, 7'd100);
    check("pre_reset_acc_nonzero", 64'(d877 != 64'd0), 64'd1);
    j99 = 1'b0;
    reset = 1'b1; h2 = 1'b1; in1 = 6'd1; bus_A = 32'hA5A5A5A5; f9 = 1'b1; j99 = 1'b1;
    module_Bus_B = 16'd7; clk_T = 7'd100;
    step();
    check_all_zero("midreset");
    reset = 1'b0; h2 = 1'b0; f9 = 1'b0; j99 = 1'b0;
    models_clear();
    rf_drive(1'b0, 6'd0, 6'd1, 32'd0, 32'd0, 1'b0);
    rf_drive(1'b0, 6'd0, 6'd41, 32'd0, 32'd0, 1'b0);
    rf_drive(1'b0, 6'd0, 6'd63, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      a = i;
      rf_model_drive(1'b0, 6'(a), 6'(a), 32'd0);
    end
    div_until_pulse(7'd3, 20, n);
    check("post_reset_div", 64'(n), 64'd4);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/top_datapath.md
Name: top_datapath

Overview:
- Mixed-function datapath block with one clock domain.
- Contains a 64x32 register file with one write port and one registered read port.
- Contains a 64-bit multiply-accumulate unit and a programmable 7-bit event divider.
- Used as a leaf peripheral: status bits and data words are registered toward the surrounding control logic.

Parameters:
- ADDR_W, 6, register-file address width (depth = 2**ADDR_W = 64).
- DATA_W, 32, register-file word width and bus_A width.
- MUL_W, 16, width of the module_Bus_B multiplier operand.
- ACC_W, 64, accumulator width.
- CNT_W, 7, divider counter and threshold width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in1  in  6  register-file write address.
- in2  in  6  register-file read address.
- h2  in  1  register-file write enable.
- f9  in  1  accumulate enable.
- jk  in  1  accumulator/overflow synchronous clear.
- j99  in  1  divider count enable.
- bus_A  in  32  write data; also multiplicand.
- clk_T  in  7  divider terminal-count value.
- module_Bus_B  in  16  multiplier.
- wrr_898  out  1  divider terminal-count pulse (registered).
- jjh  out  1  sticky accumulator overflow flag.
- d877  out  64  accumulator value.
- data_rd_T  out  32  registered read data.
- f459_87_  out  1  read/write address collision flag (registered).

Behaviour:
- Clocking and reset:
  - Single clock clk; reset is synchronous and active-high; all state updates on the rising edge.
- Reset values:
  - All outputs are 0: wrr_898, jjh, d877, data_rd_T, f459_87_.
  - All 64 register-file words are cleared to 0.
  - The divider counter is cleared to 0.
  - Reset has priority over every other input, including mid-operation.
- Register file:
  - If h2=1, mem[in1] <= bus_A.
  - Every cycle, data_rd_T <= mem[in2], so read latency is 1 cycle.
  - Write-first: if h2=1 and in1==in2, data_rd_T <= bus_A (the new data).
  - f459_87_ <= (h2 & (in1==in2)); it is a one-cycle pulse aligned with data_rd_T.
- Multiply-accumulate:
  - Product = bus_A * module_Bus_B, unsigned, 48 bits, zero-extended to 64 bits.
  - If jk=1: d877 <= 0 and jjh <= 0. jk has priority over f9.
  - Else if f9=1: d877 <= d877 + product, modulo 2^64.
  - On a carry out of bit 63, jjh <= 1. jjh stays set until jk or reset.
  - Else d877 holds.
- Divider:
  - If j99=1 and count==clk_T: count <= 0 and wrr_898 <= 1.
  - If j99=1 and count!=clk_T: count <= count+1 and wrr_898 <= 0.
  - If j99=0: count holds and wrr_898 <= 0.
  - With clk_T=0 and j99 held high, wrr_898 is high every cycle.
  - Changing clk_T while count > clk_T: the counter wraps at 127 to 0, then must reach clk_T.
  - Period with j99 held high = clk_T+1 cycles.
- No combinational input-to-output paths.

Decomposition:
- Package top_datapath_pkg holds localparams ADDR_W, DATA_W, MUL_W, ACC_W, CNT_W and the depth constant.
- Sub-module top_regfile: the 64x32 write-first, registered-read array with reset clear and the collision flag.
- The MAC and the divider stay in the top level.

Test Plan:
- Reset then idle: after reset, all outputs are 0. Then read in2=41 returns data_rd_T=0 one cycle later.
- Write/read:
  - h2=1, in1=1, bus_A=363495322 for one cycle.
  - Next cycle h2=0, in2=1 -> data_rd_T=363495322 one cycle later, f459_87_=0.
  - Collision: h2=1, in1=in2=41, bus_A=7 -> next cycle data_rd_T=7, f459_87_=1.
- MAC:
  - bus_A=363495322, module_Bus_B=53392, f9=1 for 1 cycle -> d877=19407742232224.
  - One more cycle -> 38815484464448, jjh=0.
  - jk=1 together with f9=1 -> d877=0.
- Overflow: bus_A=0xFFFFFFFF, module_Bus_B=0xFFFF, f9 held until the sum exceeds 2^64-1 -> d877 wraps, jjh=1 and stays 1 until jk.
- Divider:
  - clk_T=71, j99=1 continuously -> wrr_898 is a 1-cycle pulse every 72 cycles.
  - j99 low for 10 cycles mid-count -> the pulse is delayed by exactly 10 cycles.
  - clk_T=0 -> pulse every cycle.
- Reset mid-operation: assert reset while d877≠0, jjh=1, count=50 -> next cycle everything is 0, and memory words read back 0.
